// File: rtl/utpu_isa_pkg.sv
// Shared ISA definitions for the uTPU control path: opcode map, fetch states and
// decode helpers used by the instruction front end.
package utpu_isa_pkg;

  localparam int unsigned OPCODE_WIDTH    = 3;
  localparam int unsigned MAX_INSTR_WIDTH = 64;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OpStore = 3'd0,
    OpFetch = 3'd1,
    OpRun   = 3'd2,
    OpLoad  = 3'd3,
    OpHalt  = 3'd4,
    OpNop   = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    StFetchInstr,
    StFetchOper,
    StIssue,
    StHalted
  } fetch_state_e;

  function automatic logic is_legal_opcode(input logic [OPCODE_WIDTH-1:0] op);
    return op <= OpNop;
  endfunction

  // A STORE with the extension bit set is followed by an operand.
  function automatic logic needs_operand(input logic [MAX_INSTR_WIDTH-1:0] instr,
                                         input int unsigned                ext_bit);
    return (instr[OPCODE_WIDTH-1:0] == OpStore) && instr[ext_bit[5:0]];
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian N-byte word assembler: byte k of a word lands in bits [k*BW +: BW].
// word_o already includes a byte being loaded this cycle so the caller can decode it.
module byte_packer #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned NUM_BYTES  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear_i,
  input  logic                            load_i,
  input  logic [BYTE_WIDTH-1:0]           byte_i,
  output logic                            done_o,
  output logic [BYTE_WIDTH*NUM_BYTES-1:0] word_o
);

  localparam int unsigned WordWidth = BYTE_WIDTH * NUM_BYTES;
  localparam int unsigned IdxWidth  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NUM_BYTES - 1);

  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic [WordWidth-1:0] word_q, word_d, word_merge;

  always_comb begin
    word_merge = word_q;
    if (load_i) begin
      for (int k = 0; k < int'(NUM_BYTES); k++) begin
        if (idx_q == IdxWidth'(k)) begin
          word_merge[k*BYTE_WIDTH +: BYTE_WIDTH] = byte_i;
        end
      end
    end
  end

  always_comb begin
    idx_d  = idx_q;
    word_d = word_merge;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load_i) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign done_o = load_i && !clear_i && (idx_q == LastIdx);
  assign word_o = word_merge;

endmodule

// File: rtl/isa_fetch_decoder.sv
// uTPU instruction front end: assembles instructions (plus optional operand) from the
// RX FIFO, filters illegal/NOP opcodes and issues them over a valid/ready handshake.
module isa_fetch_decoder #(
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH   = 16,
  parameter int unsigned OPERAND_WIDTH = 16,
  parameter int unsigned OPCODE_WIDTH  = 3,
  parameter int unsigned EXT_BIT       = 4,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [BYTE_WIDTH-1:0]    fifo_rdata,
  output logic                     fifo_re,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_WIDTH-1:0]   instr_word,
  output logic [OPCODE_WIDTH-1:0]  opcode,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic                     has_operand,
  output logic                     illegal_err,
  output logic                     halted,
  output logic [COUNT_WIDTH-1:0]   instr_count
);

  import utpu_isa_pkg::*;

  localparam int unsigned INSTR_BYTES   = INSTR_WIDTH / BYTE_WIDTH;
  localparam int unsigned OPERAND_BYTES = OPERAND_WIDTH / BYTE_WIDTH;

  fetch_state_e            state_q;
  logic                    instr_valid_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic                    has_operand_q;
  logic                    illegal_q;
  logic                    halted_q;
  logic [COUNT_WIDTH-1:0]  count_q;

  logic                    instr_load, oper_load;
  logic                    instr_done, oper_done;
  logic                    oper_clear;
  logic [OPCODE_WIDTH-1:0] op_field;
  logic                    ext_needed;

  assign fifo_re = ((state_q == StFetchInstr) || (state_q == StFetchOper)) &&
                   !fifo_empty && enable;

  // Nothing is captured while reset is held, so partial words are always discarded.
  assign instr_load = fifo_re && !rst && (state_q == StFetchInstr);
  assign oper_load  = fifo_re && !rst && (state_q == StFetchOper);
  assign oper_clear = (state_q == StIssue) && instr_valid_q && instr_ready;

  byte_packer #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .NUM_BYTES (INSTR_BYTES)
  ) u_instr_packer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(1'b0),
    .load_i (instr_load),
    .byte_i (fifo_rdata),
    .done_o (instr_done),
    .word_o (instr_word)
  );

  byte_packer #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .NUM_BYTES (OPERAND_BYTES)
  ) u_oper_packer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(oper_clear),
    .load_i (oper_load),
    .byte_i (fifo_rdata),
    .done_o (oper_done),
    .word_o (operand)
  );

  assign op_field   = instr_word[OPCODE_WIDTH-1:0];
  assign ext_needed = needs_operand(MAX_INSTR_WIDTH'(instr_word), EXT_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetchInstr;
      instr_valid_q <= 1'b0;
      opcode_q      <= '0;
      has_operand_q <= 1'b0;
      illegal_q     <= 1'b0;
      halted_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      unique case (state_q)
        StFetchInstr: begin
          if (instr_done) begin
            if (!is_legal_opcode(op_field)) begin
              illegal_q <= 1'b1;
            end else if (op_field != OPCODE_WIDTH'(OpNop)) begin
              opcode_q <= op_field;
              if (ext_needed) begin
                state_q <= StFetchOper;
              end else begin
                state_q       <= StIssue;
                instr_valid_q <= 1'b1;
              end
            end
          end
        end
        StFetchOper: begin
          if (oper_done) begin
            state_q       <= StIssue;
            instr_valid_q <= 1'b1;
            has_operand_q <= 1'b1;
          end
        end
        StIssue: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            has_operand_q <= 1'b0;
            count_q       <= count_q + COUNT_WIDTH'(1);
            if (opcode_q == OPCODE_WIDTH'(OpHalt)) begin
              state_q  <= StHalted;
              halted_q <= 1'b1;
            end else begin
              state_q <= StFetchInstr;
            end
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q <= StFetchInstr;
        end
      endcase
    end
  end

  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_q;
  assign has_operand = has_operand_q;
  assign illegal_err = illegal_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_isa_fetch_decoder.sv
// Directed bench for isa_fetch_decoder with a small first-word-fall-through FIFO model.
module tb_isa_fetch_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_re;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_word;
  logic [2:0]  opcode;
  logic [15:0] operand;
  logic        has_operand;
  logic        illegal_err;
  logic        halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  bit seen;
  int cyc;

  logic [7:0]  mem [64];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr[5:0]];

  always @(posedge clk) if (fifo_re) rd_ptr <= rd_ptr + 1;

  always #5 clk = ~clk;

  isa_fetch_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_re    (fifo_re),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_word (instr_word),
    .opcode     (opcode),
    .operand    (operand),
    .has_operand(has_operand),
    .illegal_err(illegal_err),
    .halted     (halted),
    .instr_count(instr_count)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got, output int cycles);
    got    = instr_valid;
    cycles = 0;
    while (!got && cycles < budget) begin
      step();
      cycles++;
      got = instr_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    step();
    step();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", instr_valid); end
    total++; if (instr_word !== 16'h0) begin bad++; $display("FAIL reset_word got=%0h want=0", instr_word); end
    total++; if (opcode !== 3'd0) begin bad++; $display("FAIL reset_opcode got=%0h want=0", opcode); end
    total++; if (operand !== 16'h0) begin bad++; $display("FAIL reset_operand got=%0h want=0", operand); end
    total++; if (has_operand !== 1'b0) begin bad++; $display("FAIL reset_has_op got=%0h want=0", has_operand); end
    total++; if (illegal_err !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0h want=0", illegal_err); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0h want=0", halted); end
    total++; if (instr_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0h want=0", instr_count); end
    total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL reset_fifo_re got=%0h want=0", fifo_re); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    instr_ready = 1'b1;
    push(8'h12);
    push(8'h34);
    #1;
    total++; if (fifo_re !== 1'b1) begin bad++; $display("FAIL basic_re0 got=%0h want=1", fifo_re); end
    step();
    total++; if (fifo_re !== 1'b1) begin bad++; $display("FAIL basic_re1 got=%0h want=1", fifo_re); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0h want=0", instr_valid); end
    step();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h want=1", instr_valid); end
    total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL basic_re_issue got=%0h want=0", fifo_re); end
    total++; if (instr_word !== 16'h3412) begin bad++; $display("FAIL basic_word got=%0h want=3412", instr_word); end
    total++; if (opcode !== 3'd2) begin bad++; $display("FAIL basic_opcode got=%0h want=2", opcode); end
    total++; if (has_operand !== 1'b0) begin bad++; $display("FAIL basic_has_op got=%0h want=0", has_operand); end
    step();
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", instr_count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0h want=0", instr_valid); end
  endtask

  task automatic test_store_operand();
    instr_ready = 1'b0;
    push(8'h10); push(8'h00); push(8'hCD); push(8'hAB);
    wait_valid(12, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL store_timeout got=no_valid want=valid"); end
    total++; if (cyc !== 4) begin bad++; $display("FAIL store_latency got=%0d want=4", cyc); end
    total++; if (opcode !== 3'd0) begin bad++; $display("FAIL store_opcode got=%0h want=0", opcode); end
    total++; if (has_operand !== 1'b1) begin bad++; $display("FAIL store_has_op got=%0h want=1", has_operand); end
    total++; if (operand !== 16'hABCD) begin bad++; $display("FAIL store_operand got=%0h want=abcd", operand); end
    total++; if (instr_word !== 16'h0010) begin bad++; $display("FAIL store_word got=%0h want=0010", instr_word); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL store_count got=%0d want=2", instr_count); end
    total++; if (has_operand !== 1'b0) begin bad++; $display("FAIL store_has_op_clr got=%0h want=0", has_operand); end
    total++; if (operand !== 16'h0) begin bad++; $display("FAIL store_operand_clr got=%0h want=0", operand); end
  endtask

  task automatic test_hold();
    instr_ready = 1'b0;
    push(8'h02); push(8'h00); push(8'h01); push(8'h00);
    wait_valid(10, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL hold_timeout got=no_valid want=valid"); end
    for (int i = 0; i < 5; i++) begin
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%0h want=1", i, instr_valid); end
      total++; if (instr_word !== 16'h0002) begin bad++; $display("FAIL hold_word[%0d] got=%0h want=0002", i, instr_word); end
      total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL hold_re[%0d] got=%0h want=0", i, fifo_re); end
      total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL hold_count[%0d] got=%0d want=2", i, instr_count); end
      step();
    end
    instr_ready = 1'b1;
    step();
    total++; if (instr_count !== 16'd3) begin bad++; $display("FAIL hold_accept_count got=%0d want=3", instr_count); end
    wait_valid(10, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL hold_next_timeout got=no_valid want=valid"); end
    total++; if (instr_word !== 16'h0001) begin bad++; $display("FAIL hold_next_word got=%0h want=0001", instr_word); end
    total++; if (opcode !== 3'd1) begin bad++; $display("FAIL hold_next_opcode got=%0h want=1", opcode); end
    step();
    instr_ready = 1'b0;
    total++; if (instr_count !== 16'd4) begin bad++; $display("FAIL hold_next_count got=%0d want=4", instr_count); end
  endtask

  task automatic test_illegal_nop();
    instr_ready = 1'b0;
    do_reset();
    push(8'h07); push(8'h00); push(8'h05); push(8'h00); push(8'h03); push(8'h01);
    wait_valid(20, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL illnop_timeout got=no_valid want=valid"); end
    total++; if (cyc !== 6) begin bad++; $display("FAIL illnop_latency got=%0d want=6", cyc); end
    total++; if (illegal_err !== 1'b1) begin bad++; $display("FAIL illnop_err got=%0h want=1", illegal_err); end
    total++; if (instr_word !== 16'h0103) begin bad++; $display("FAIL illnop_word got=%0h want=0103", instr_word); end
    total++; if (opcode !== 3'd3) begin bad++; $display("FAIL illnop_opcode got=%0h want=3", opcode); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL illnop_count_pre got=%0d want=0", instr_count); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL illnop_count got=%0d want=1", instr_count); end
    total++; if (illegal_err !== 1'b1) begin bad++; $display("FAIL illnop_err_sticky got=%0h want=1", illegal_err); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL illnop_valid_drop got=%0h want=0", instr_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    instr_ready = 1'b1;
    push(8'h04); push(8'h00); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    wait_valid(10, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL halt_timeout got=no_valid want=valid"); end
    total++; if (opcode !== 3'd4) begin bad++; $display("FAIL halt_opcode got=%0h want=4", opcode); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%0h want=0", halted); end
    step();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%0h want=1", halted); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL halt_count got=%0d want=1", instr_count); end
    for (int i = 0; i < 6; i++) begin
      total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL halt_re[%0d] got=%0h want=0", i, fifo_re); end
      step();
    end
    total++; if ((wr_ptr - rd_ptr) !== 4) begin bad++; $display("FAIL halt_fifo_left got=%0d want=4", wr_ptr - rd_ptr); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_stays got=%0h want=1", halted); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_ptr = rd_ptr;
    do_reset();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL mid_halt_clr got=%0h want=0", halted); end
    push(8'h12);
    step();
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL mid_popped got=%0h want=1", fifo_empty); end
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    instr_ready = 1'b1;
    push(8'h02); push(8'h00);
    wait_valid(10, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL mid_timeout got=no_valid want=valid"); end
    total++; if (cyc !== 2) begin bad++; $display("FAIL mid_latency got=%0d want=2", cyc); end
    total++; if (instr_word !== 16'h0002) begin bad++; $display("FAIL mid_word got=%0h want=0002", instr_word); end
    total++; if (opcode !== 3'd2) begin bad++; $display("FAIL mid_opcode got=%0h want=2", opcode); end
    step();
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL mid_count got=%0d want=1", instr_count); end
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b1;
    push(8'h02); push(8'h00); push(8'h02); push(8'h00); push(8'h02); push(8'h00);
    repeat (8) step();
    total++; if (instr_count !== 16'd3) begin bad++; $display("FAIL b2b_count8 got=%0d want=3", instr_count); end
    step();
    total++; if (instr_count !== 16'd4) begin bad++; $display("FAIL b2b_count9 got=%0d want=4", instr_count); end
  endtask

  task automatic test_rst_handshake();
    instr_ready = 1'b0;
    push(8'h02); push(8'h00);
    wait_valid(10, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL rsths_timeout got=no_valid want=valid"); end
    rst = 1'b1;
    instr_ready = 1'b1;
    step();
    rst = 1'b0;
    instr_ready = 1'b0;
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL rsths_count got=%0d want=0", instr_count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rsths_valid got=%0h want=0", instr_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_store_operand();
    test_hold();
    test_illegal_nop();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_rst_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
